// File: rtl/gf26_pkg.sv
// ============================================================================
// Module : gf26_pkg
// Brief  : GF(2^6) field constants, log-search state type, multiply-by-alpha.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gf26_pkg;

    localparam int          M         = 6;
    localparam logic [6:0]  PRIM_POLY = 7'h43;
    localparam logic [5:0]  ALPHA     = 6'h02;
    localparam int          ORDER     = 63;

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } log_state_t;

    // x^6 folds back as x+1, i.e. the low six bits of the primitive polynomial
    function automatic logic [5:0] gf26_mul_alpha(input logic [5:0] a);
        return {a[4:0], 1'b0} ^ (a[5] ? PRIM_POLY[5:0] : 6'h00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gf26_log.sv
// ============================================================================
// Module : gf26_log
// Brief  : Iterative GF(2^6) discrete log: steps alpha^i until it equals y.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gf26_log
    import gf26_pkg::*;
#(
    parameter int M     = 6,
    parameter int MAX_K = 62
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [M-1:0] y,
    output logic         finish_flag,
    output logic         err_flag,
    output logic [M-1:0] k
);

    localparam logic [M-1:0] C_MAX_K = MAX_K[M-1:0];
    localparam logic [M-1:0] C_ONE   = M'(1);

    log_state_t   r_state;
    log_state_t   w_state_nxt;
    logic         r_start_d;
    logic [M-1:0] r_y,      w_y_nxt;
    logic [M-1:0] r_acc,    w_acc_nxt;
    logic [M-1:0] r_cnt,    w_cnt_nxt;
    logic         r_finish, w_finish_nxt;
    logic         r_err,    w_err_nxt;
    logic [M-1:0] r_k,      w_k_nxt;

    logic w_edge;
    logic w_zero;
    logic w_match;
    logic w_exhausted;

    assign w_edge      = start & ~r_start_d;
    assign w_zero      = (r_y == '0);
    assign w_match     = (r_acc == r_y);
    assign w_exhausted = (r_cnt == C_MAX_K);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_start_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_d <= start;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_edge) w_state_nxt = SEARCH;
            SEARCH:  if (w_zero || w_match || w_exhausted) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath and result next-values; results hold unless a search concludes
    always_comb begin
        w_y_nxt      = r_y;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_finish_nxt = r_finish;
        w_err_nxt    = r_err;
        w_k_nxt      = r_k;
        case (r_state)
            IDLE: begin
                if (w_edge) begin
                    w_y_nxt      = y;
                    w_acc_nxt    = C_ONE;
                    w_cnt_nxt    = '0;
                    w_finish_nxt = 1'b0;
                    w_err_nxt    = 1'b0;
                end
            end
            SEARCH: begin
                if (w_zero) begin
                    w_err_nxt    = 1'b1;
                    w_k_nxt      = '0;
                    w_finish_nxt = 1'b1;
                end else if (w_match) begin
                    w_k_nxt      = r_cnt;
                    w_finish_nxt = 1'b1;
                end else if (w_exhausted) begin
                    // Unreachable for a primitive polynomial; bounds the search
                    w_err_nxt    = 1'b1;
                    w_k_nxt      = '0;
                    w_finish_nxt = 1'b1;
                end else begin
                    w_acc_nxt    = gf26_mul_alpha(r_acc);
                    w_cnt_nxt    = r_cnt + C_ONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_y      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_finish <= 1'b0;
            r_err    <= 1'b0;
            r_k      <= '0;
        end else begin
            r_y      <= w_y_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_finish <= w_finish_nxt;
            r_err    <= w_err_nxt;
            r_k      <= w_k_nxt;
        end
    end

    assign finish_flag = r_finish;
    assign err_flag    = r_err;
    assign k           = r_k;

endmodule

`default_nettype wire

// File: tb/tb_gf26_log.sv
// ============================================================================
// Module : tb_gf26_log
// Brief  : Scoreboard bench for gf26_log: directed logs, handshake, reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gf26_log;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] y;
    logic       finish_flag;
    logic       err_flag;
    logic [5:0] k;

    typedef struct {
        logic [5:0] k;
        logic       err;
        int         t0;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   results  = 0;
    logic prev_fin = 1'b0;

    gf26_log #(.M(6), .MAX_K(62)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .y           (y),
        .finish_flag (finish_flag),
        .err_flag    (err_flag),
        .k           (k)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Independent GF(2^6) multiply: carry-less product reduced by x^6+x+1
    function automatic logic [5:0] ref_mul(input logic [5:0] a, input logic [5:0] b);
        logic [11:0] prod;
        prod = '0;
        for (int i = 0; i < 6; i++)
            if (b[i]) prod = prod ^ (12'(a) << i);
        for (int i = 11; i >= 6; i--)
            if (prod[i]) prod = prod ^ (12'h043 << (i - 6));
        return prod[5:0];
    endfunction

    // Monitor: each rising edge of finish_flag consumes one expectation
    always @(negedge clk) begin
        if (finish_flag === 1'b1 && prev_fin !== 1'b1) begin
            results++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual_k=%0d expected=none", k);
            end else begin
                e = sb.pop_front();
                chk("k", 32'(k), 32'(e.k));
                chk("err_flag", 32'(err_flag), 32'(e.err));
                chk("latency", 32'(cyc - e.t0), 32'(int'(e.k) + 2));
            end
        end
        prev_fin = finish_flag;
    end

    task automatic wait_done();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        chk("timeout_pending", 32'(sb.size()), 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic push_exp(input logic [5:0] ek, input logic ee);
        exp_t x;
        x.k   = ek;
        x.err = ee;
        x.t0  = cyc;
        sb.push_back(x);
    endtask

    task automatic issue(input logic [5:0] yv, input logic [5:0] ek, input logic ee);
        @(negedge clk);
        y     = yv;
        start = 1'b1;
        push_exp(ek, ee);
        @(negedge clk);
        start = 1'b0;
        chk("accept_clears_finish", 32'(finish_flag), 32'd0);
        chk("accept_clears_err", 32'(err_flag), 32'd0);
        wait_done();
    endtask

    initial begin
        int         r0;
        logic [5:0] p;

        reset = 1'b1;
        start = 1'b0;
        y     = 6'h00;
        repeat (3) @(negedge clk);
        chk("reset_finish", 32'(finish_flag), 32'd0);
        chk("reset_err", 32'(err_flag), 32'd0);
        chk("reset_k", 32'(k), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        issue(6'h01, 6'd0, 1'b0);
        issue(6'h02, 6'd1, 1'b0);
        issue(6'h03, 6'd6, 1'b0);

        repeat (20) @(negedge clk);
        chk("hold_finish", 32'(finish_flag), 32'd1);
        chk("hold_k", 32'(k), 32'd6);

        // Asynchronous reset in the middle of a long search
        @(negedge clk);
        y     = 6'h21;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_reset_finish", 32'(finish_flag), 32'd0);
        chk("async_reset_err", 32'(err_flag), 32'd0);
        chk("async_reset_k", 32'(k), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        issue(6'h01, 6'd0, 1'b0);

        issue(6'h23, 6'd11, 1'b0);
        issue(6'h21, 6'd62, 1'b0);
        issue(6'h00, 6'd0, 1'b1);
        issue(6'h04, 6'd2, 1'b0);

        // Start held high for 100 cycles: exactly one computation
        r0 = results;
        @(negedge clk);
        y     = 6'h02;
        start = 1'b1;
        push_exp(6'd1, 1'b0);
        repeat (100) @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_start_results", 32'(results - r0), 32'd1);
        chk("held_start_pending", 32'(sb.size()), 32'd0);
        sb.delete();

        // Second rising edge during SEARCH is ignored
        r0 = results;
        @(negedge clk);
        y     = 6'h21;
        start = 1'b1;
        push_exp(6'd62, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        y     = 6'h05;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        y     = 6'h00;
        wait_done();
        repeat (5) @(negedge clk);
        chk("ignored_edge_results", 32'(results - r0), 32'd1);

        p = 6'h01;
        for (int i = 0; i <= 62; i++) begin
            issue(p, 6'(i), 1'b0);
            p = ref_mul(p, 6'h02);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gf26_log.md
Name: gf26_log

Overview:
- Computes the discrete logarithm in GF(2^6): for input y, returns k (0..62) such that alpha^k = y.
- Is the reverse-direction companion of the GF(2^6) exponentiation/inverse path.
- Converts field elements produced by the Reed-Solomon datapath back to exponent form for syndrome/locator bookkeeping.
- Works iteratively: it steps alpha^i until the power matches y, then reports i.

Parameters:
- M, 6, field degree (symbol width).
- MAX_K, 62, last valid exponent (2^M - 2); the search gives up after this.

Ports:
- clk  input  1  system clock
- reset  input  1  reset; one clock; asynchronous, active-high
- start  input  1  request; acted on at its rising edge only (start & !start_d)
- y  input  M  field element whose log is required; sampled on the accepted edge
- finish_flag  output  1  high when k/err_flag are valid; held until next accepted start
- err_flag  output  1  high with finish_flag when no log exists (y==0)
- k  output  M  exponent result; 0 when err_flag=1

Behaviour:
- Field: primitive polynomial x^6+x+1 (7'h43), alpha = 6'h02.
- Multiply-by-alpha: {a[4:0],1'b0} ^ (a[5] ? 6'h03 : 6'h00).
- Reset (asynchronous, any time, including mid-search):
  - state=IDLE; start_d=0; y_r=0; acc=0; cnt=0.
  - finish_flag=0, err_flag=0, k=0.
  - No partial result survives reset.
- start_d is a registered copy of start, updated every cycle.
- FSM states: IDLE, SEARCH.
- IDLE:
  - On start & !start_d: latch y_r=y, acc=6'h01, cnt=0; clear finish_flag and err_flag; go to SEARCH.
  - Otherwise stay; outputs hold their last values.
- SEARCH (one compare per cycle):
  - y_r==0: err_flag<=1, k<=0, finish_flag<=1, go to IDLE.
  - Else if acc==y_r: k<=cnt, finish_flag<=1, go to IDLE.
  - Else if cnt==MAX_K: err_flag<=1, k<=0, finish_flag<=1, go to IDLE. This is a guard only; it is unreachable with a primitive polynomial.
  - Else: acc<=acc*alpha, cnt<=cnt+1, stay in SEARCH.
- Latency: edge sampled at cycle T -> finish_flag high at T+2+k.
  - y=1: 2 cycles.
  - y=0: 2 cycles.
  - Worst case k=62: 64 cycles.
- start edges while in SEARCH are ignored (no queueing, no restart). A start held high across the return to IDLE does not retrigger; a new rising edge is required.
- A start edge in the same cycle the FSM returns to IDLE is ignored, because the FSM was still in SEARCH when it was sampled.
- k, err_flag and finish_flag are registered outputs with no combinational path from inputs.
- Width rules: cnt is M bits and never exceeds MAX_K; acc stays M bits after reduction.

Decomposition:
- gf26_pkg holds:
  - M, PRIM_POLY=7'h43, ALPHA=6'h02, ORDER=63.
  - typedef enum logic {IDLE,SEARCH} log_state_t.
  - Function gf26_mul_alpha(logic [5:0]) returning logic [5:0]. It is shared with the exponent blocks.
- No sub-module: the multiply-by-alpha is a single function, and the FSM plus counter fit in one module.

Test Plan:
- Reset mid-search: y=6'h21 accepted, assert reset 10 cycles later -> all outputs 0 immediately (asynchronous). After release, a fresh edge with y=6'h01 yields k=0.
- Basic values:
  - y=6'h01 -> finish_flag at T+2, k=0, err_flag=0.
  - y=6'h02 -> k=1 at T+3.
  - y=6'h03 -> k=6 at T+8.
- Wrap region:
  - y=6'h23 -> k=11 at T+13.
  - y=6'h21 (alpha^-1) -> k=62 at T+64, err_flag=0.
- Zero input: y=6'h00 -> finish_flag=1, err_flag=1, k=0 at T+2. A following start edge with y=6'h04 clears both flags on acceptance and yields k=2.
- Handshake:
  - start held high for 100 cycles -> exactly one computation.
  - A second rising edge during SEARCH is ignored; the result matches the first y.
  - finish_flag stays high until the next accepted edge.
- Exhaustive: for every k in 0..62, y=alpha^k from a reference model -> k returned, latency k+2.
